// File: rtl/memory_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, grant owner and data word.
package memory_arbiter_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Pipeline-side request/hit signals and RAM-side strobe/ready signals of the memory arbiter.
//
// Handshake rules: a requester raises imemREN or dmemREN/dmemWEN and holds it, with stable
// address/data, until the matching ihit/dhit pulse; the hit is a single-cycle pulse and the load
// data is valid only in that cycle. On the RAM side the arbiter holds ramREN/ramWEN, ramaddr and
// ramstore stable until ram_ready is sampled high; ramload is valid in the ram_ready cycle.
interface memory_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          imemREN;
  logic [AW-1:0] imemaddr;
  logic [DW-1:0] imemload;
  logic          ihit;

  logic          dmemREN;
  logic          dmemWEN;
  logic [AW-1:0] dmemaddr;
  logic [DW-1:0] dmemstore;
  logic [DW-1:0] dmemload;
  logic          dhit;
  logic          mem_err;

  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload;
  logic          ram_ready;

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload, ram_ready,
    output imemload, ihit, dmemload, dhit, mem_err, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload, ram_ready,
    input  imemload, ihit, dmemload, dhit, mem_err, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/memory_arbiter_watchdog.sv
// Access watchdog: counts enabled cycles and flags the cycle in which the count reaches TIMEOUT.
module mem_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (RST || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CW'(TIMEOUT))) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Combinational so the FSM leaves ACCESS at the edge that completes the TIMEOUT-th cycle.
  assign o_expired = i_enable && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/memory_arbiter.sv
// Single-ported RAM arbiter for instruction fetch and data access: data has priority, with a
// bounded data streak so a pending fetch cannot starve. All outputs are registered.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic               CLK,
  input  logic               RST,
  memory_arbiter_if.slave    io_bus,
  output arb_state_t         o_dbg_state
);

  localparam int            SW         = $clog2(MAX_DSTREAK + 1);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

  arb_state_t    r_state;
  arb_state_t    w_next;
  owner_t        r_owner;
  logic [SW-1:0] r_streak;

  logic          r_ram_ren;
  logic          r_ram_wen;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_store;
  logic          r_ihit;
  logic          r_dhit;
  logic          r_mem_err;
  logic [DW-1:0] r_iload;
  logic [DW-1:0] r_dload;

  logic          w_data_req;
  logic          w_force_fetch;
  logic          w_grant_d;
  logic          w_grant_i;
  logic          w_expired;
  logic          w_finish;
  logic          w_owner_live;

  logic          w_ram_ren_d;
  logic          w_ram_wen_d;
  logic [AW-1:0] w_ram_addr_d;
  logic [DW-1:0] w_ram_store_d;
  logic          w_ihit_d;
  logic          w_dhit_d;
  logic          w_mem_err_d;
  logic [DW-1:0] w_iload_d;
  logic [DW-1:0] w_dload_d;
  logic [SW-1:0] w_streak_d;
  owner_t        w_owner_d;

  assign w_data_req    = io_bus.dmemREN || io_bus.dmemWEN;
  assign w_force_fetch = io_bus.imemREN && (r_streak == SW'(MAX_DSTREAK));
  assign w_grant_d     = (r_state == IDLE) && w_data_req && !w_force_fetch;
  assign w_grant_i     = (r_state == IDLE) && io_bus.imemREN && (!w_data_req || w_force_fetch);
  assign w_finish      = (r_state == ACCESS) && (io_bus.ram_ready || w_expired);
  // A requester that dropped its request mid-access gets no hit; the result is thrown away.
  assign w_owner_live  = (r_owner == OWN_D) ? w_data_req : io_bus.imemREN;

  mem_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .CLK      (CLK),
    .RST      (RST),
    .i_clear  (r_state != ACCESS),
    .i_enable (r_state == ACCESS),
    .o_expired(w_expired)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant_d || w_grant_i) w_next = ACCESS;
      ACCESS:  if (io_bus.ram_ready || w_expired) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_ram_ren_d   = r_ram_ren;
    w_ram_wen_d   = r_ram_wen;
    w_ram_addr_d  = r_ram_addr;
    w_ram_store_d = r_ram_store;
    w_ihit_d      = 1'b0;
    w_dhit_d      = 1'b0;
    w_mem_err_d   = 1'b0;
    w_iload_d     = r_iload;
    w_dload_d     = r_dload;
    w_streak_d    = r_streak;
    w_owner_d     = r_owner;

    if (w_grant_d) begin
      // A simultaneous read and write request is serviced as the write.
      w_ram_ren_d   = !io_bus.dmemWEN;
      w_ram_wen_d   = io_bus.dmemWEN;
      w_ram_addr_d  = io_bus.dmemaddr & ALIGN_MASK;
      w_ram_store_d = io_bus.dmemstore;
      w_owner_d     = OWN_D;
      if (!io_bus.imemREN) begin
        w_streak_d = '0;
      end else if (r_streak != SW'(MAX_DSTREAK)) begin
        w_streak_d = r_streak + SW'(1);
      end
    end else if (w_grant_i) begin
      w_ram_ren_d  = 1'b1;
      w_ram_wen_d  = 1'b0;
      w_ram_addr_d = io_bus.imemaddr & ALIGN_MASK;
      w_owner_d    = OWN_I;
      w_streak_d   = '0;
    end

    if (w_finish) begin
      w_ram_ren_d = 1'b0;
      w_ram_wen_d = 1'b0;
      if (w_owner_live) begin
        w_mem_err_d = !io_bus.ram_ready;
        if (r_owner == OWN_D) begin
          w_dhit_d  = 1'b1;
          w_dload_d = (io_bus.ram_ready && !r_ram_wen) ? io_bus.ramload : '0;
        end else begin
          w_ihit_d  = 1'b1;
          w_iload_d = io_bus.ram_ready ? io_bus.ramload : '0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ram_ren   <= 1'b0;
      r_ram_wen   <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_store <= '0;
      r_ihit      <= 1'b0;
      r_dhit      <= 1'b0;
      r_mem_err   <= 1'b0;
      r_iload     <= '0;
      r_dload     <= '0;
      r_streak    <= '0;
      r_owner     <= OWN_I;
    end else begin
      r_ram_ren   <= w_ram_ren_d;
      r_ram_wen   <= w_ram_wen_d;
      r_ram_addr  <= w_ram_addr_d;
      r_ram_store <= w_ram_store_d;
      r_ihit      <= w_ihit_d;
      r_dhit      <= w_dhit_d;
      r_mem_err   <= w_mem_err_d;
      r_iload     <= w_iload_d;
      r_dload     <= w_dload_d;
      r_streak    <= w_streak_d;
      r_owner     <= w_owner_d;
    end
  end

  assign io_bus.ramREN   = r_ram_ren;
  assign io_bus.ramWEN   = r_ram_wen;
  assign io_bus.ramaddr  = r_ram_addr;
  assign io_bus.ramstore = r_ram_store;
  assign io_bus.ihit     = r_ihit;
  assign io_bus.dhit     = r_dhit;
  assign io_bus.mem_err  = r_mem_err;
  assign io_bus.imemload = r_iload;
  assign io_bus.dmemload = r_dload;
  assign o_dbg_state     = r_state;

endmodule
